// File: rtl/uart_rx_frame_if.sv
// Receive-side handshake bundle for uart_rx_frame.
// The receiver is the master and drives the held word and its flags.
// The consumer is the slave and drives rx_ready.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx_ready;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_overrun;

    modport master (
        input  rx_ready,
        output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_overrun
    );

    modport slave (
        output rx_ready,
        input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_overrun
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// The line is synchronised and every bit is decided by a 2-of-3 vote around mid-bit.
// The completed word and its error flags sit in an output register with valid/ready.
module uart_rx_frame #(
    parameter int CLK_RATE  = 12500000,
    parameter int UART_BAUD = 921600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            uart_rx,
    uart_rx_frame_if.master rx_if
);

    localparam int CLKS_PER_BIT = CLK_RATE / UART_BAUD;
    localparam int HALF         = (CLKS_PER_BIT - 32'sd1) / 32'sd2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 32'sd1);
    localparam logic [CNT_W-1:0] SAMP_A    = CNT_W'(HALF - 32'sd1);
    localparam logic [CNT_W-1:0] SAMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMP_C    = CNT_W'(HALF + 32'sd1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 32'sd1);
    localparam logic             STOP_LAST = (STOP_BITS == 32'sd2);
    localparam logic             HAS_PAR   = (PARITY != 32'sd0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // Parity check of a received word: 1 means the parity bit disagrees.
    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic par_bit);
        logic x;
        x = (^data) ^ par_bit;
        if (PARITY == 32'sd1) begin
            parity_err_f = ~x;
        end else if (PARITY == 32'sd2) begin
            parity_err_f = x;
        end else begin
            parity_err_f = 1'b0;
        end
    endfunction

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_rxs;
    logic                 r_rxs_prev;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_s1;
    logic                 r_s2;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_frame_err;
    logic                 r_stop0_zero;

    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_parity_err;
    logic                 r_frame_err_o;
    logic                 r_break;
    logic                 r_overrun;

    logic w_fall;
    logic w_tick_end;
    logic w_decide;
    logic w_bit;
    logic w_start_cnt;
    logic w_counting;
    logic w_shift_en;
    logic w_par_en;
    logic w_stop_en;
    logic w_complete;
    logic w_frame_err;
    logic w_stop0_zero;
    logic w_break;
    logic w_xfer;

    assign w_fall       = r_rxs_prev & ~r_rxs;
    assign w_tick_end   = (r_bit_cnt == CNT_LAST);
    assign w_decide     = (r_bit_cnt == SAMP_C);
    assign w_bit        = (r_s1 & r_s2) | (r_s1 & r_rxs) | (r_s2 & r_rxs);
    assign w_complete   = w_stop_en && (r_stop_idx == STOP_LAST);
    assign w_frame_err  = r_frame_err | ~w_bit;
    assign w_stop0_zero = (r_stop_idx == 1'b0) ? ~w_bit : r_stop0_zero;
    assign w_break      = (r_shift == '0) && (!HAS_PAR || !r_par_bit) && w_stop0_zero;
    assign w_xfer       = r_valid & rx_if.rx_ready;

    // Two-flop synchroniser plus one history flop for edge detection; preset high so reset is not a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= uart_rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; a frame with a bad stop bit waits for the line to return high.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_next = S_START;
                else        w_next = S_IDLE;
            end
            S_START: begin
                if (w_decide && w_bit) w_next = S_IDLE;
                else if (w_tick_end)   w_next = S_DATA;
                else                   w_next = S_START;
            end
            S_DATA: begin
                if (w_tick_end && (r_bit_idx == DATA_LAST)) w_next = HAS_PAR ? S_PARITY : S_STOP;
                else                                        w_next = S_DATA;
            end
            S_PARITY: begin
                if (w_tick_end) w_next = S_STOP;
                else            w_next = S_PARITY;
            end
            S_STOP: begin
                if (w_complete) w_next = w_frame_err ? S_WAIT_HIGH : S_IDLE;
                else            w_next = S_STOP;
            end
            S_WAIT_HIGH: begin
                if (r_rxs) w_next = S_IDLE;
                else       w_next = S_WAIT_HIGH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM output decode: which bit period is running and which capture strobes fire.
    always_comb begin
        w_start_cnt = 1'b0;
        w_counting  = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_stop_en   = 1'b0;
        case (r_state)
            S_IDLE:   w_start_cnt = w_fall;
            S_START:  w_counting  = 1'b1;
            S_DATA: begin
                w_counting = 1'b1;
                w_shift_en = w_decide;
            end
            S_PARITY: begin
                w_counting = 1'b1;
                w_par_en   = w_decide;
            end
            S_STOP: begin
                w_counting = 1'b1;
                w_stop_en  = w_decide;
            end
            S_WAIT_HIGH: w_counting = 1'b0;
            default:     w_counting = 1'b0;
        endcase
    end

    // Bit timing: the edge-detect cycle is count 0, so the first counted cycle loads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_bit_idx  <= 4'd0;
            r_stop_idx <= 1'b0;
        end else begin
            if (w_start_cnt) begin
                r_bit_cnt <= CNT_W'(1);
            end else if (w_counting) begin
                r_bit_cnt <= w_tick_end ? '0 : r_bit_cnt + CNT_W'(1);
            end else begin
                r_bit_cnt <= '0;
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= 4'd0;
            end else if (w_tick_end) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end
            if (r_state != S_STOP) begin
                r_stop_idx <= 1'b0;
            end else if (w_tick_end) begin
                r_stop_idx <= 1'b1;
            end
        end
    end

    // Early and middle vote samples; the third is the live line at the decision cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            if (r_bit_cnt == SAMP_A) r_s1 <= r_rxs;
            if (r_bit_cnt == SAMP_B) r_s2 <= r_rxs;
        end
    end

    // Frame assembly: data shifts in LSB first from the top, plus parity and stop-bit history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_stop0_zero <= 1'b0;
        end else begin
            if (w_start_cnt) begin
                r_par_bit    <= 1'b0;
                r_frame_err  <= 1'b0;
                r_stop0_zero <= 1'b0;
            end
            if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (w_par_en)   r_par_bit <= w_bit;
            if (w_stop_en && !w_bit) r_frame_err <= 1'b1;
            if (w_stop_en && (r_stop_idx == 1'b0)) r_stop0_zero <= ~w_bit;
        end
    end

    // Output holding register: load on completion when free or being emptied, else flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_parity_err  <= 1'b0;
            r_frame_err_o <= 1'b0;
            r_break       <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_complete && (!r_valid || w_xfer)) begin
            r_valid       <= 1'b1;
            r_data        <= r_shift;
            r_parity_err  <= parity_err_f(r_shift, r_par_bit);
            r_frame_err_o <= w_frame_err;
            r_break       <= w_break;
            r_overrun     <= 1'b0;
        end else if (w_xfer) begin
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_parity_err  <= 1'b0;
            r_frame_err_o <= 1'b0;
            r_break       <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_complete) begin
            r_overrun     <= 1'b1;
        end
    end

    assign rx_if.rx_valid      = r_valid;
    assign rx_if.rx_data       = r_data;
    assign rx_if.rx_parity_err = r_parity_err;
    assign rx_if.rx_frame_err  = r_frame_err_o;
    assign rx_if.rx_break      = r_break;
    assign rx_if.rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances (8N1, 8E2, 7N1) at 13 clk per bit.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] line;
    logic [2:0] rdy;

    always #5 clk = ~clk;

    uart_rx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_rx_frame_if #(.DATA_BITS(8)) if1 ();
    uart_rx_frame_if #(.DATA_BITS(7)) if2 ();

    assign if0.rx_ready = rdy[0];
    assign if1.rx_ready = rdy[1];
    assign if2.rx_ready = rdy[2];

    uart_rx_frame #(.CLK_RATE(12500000), .UART_BAUD(921600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .uart_rx(line[0]), .rx_if(if0));
    uart_rx_frame #(.CLK_RATE(12500000), .UART_BAUD(921600), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
        u_dut1 (.clk(clk), .rst_n(rst_n), .uart_rx(line[1]), .rx_if(if1));
    uart_rx_frame #(.CLK_RATE(12500000), .UART_BAUD(921600), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .uart_rx(line[2]), .rx_if(if2));

    logic [2:0] w_valid;
    logic [8:0] w_data  [3];
    logic [3:0] w_flags [3];   // {parity_err, frame_err, break, overrun}

    assign w_valid    = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
    assign w_data[0]  = {1'b0, if0.rx_data};
    assign w_data[1]  = {1'b0, if1.rx_data};
    assign w_data[2]  = {2'b00, if2.rx_data};
    assign w_flags[0] = {if0.rx_parity_err, if0.rx_frame_err, if0.rx_break, if0.rx_overrun};
    assign w_flags[1] = {if1.rx_parity_err, if1.rx_frame_err, if1.rx_break, if1.rx_overrun};
    assign w_flags[2] = {if2.rx_parity_err, if2.rx_frame_err, if2.rx_break, if2.rx_overrun};

    int nbits   [3] = '{8, 8, 7};
    int has_par [3] = '{0, 1, 0};
    int nstop   [3] = '{1, 2, 1};

    int         wcnt       [3] = '{0, 0, 0};
    logic [8:0] last_data  [3];
    logic [3:0] last_flags [3];

    int n_total = 0;
    int n_pass  = 0;
    int lat     = 0;

    // Word monitor: count and capture every handshake, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (w_valid[d] && rdy[d]) begin
                wcnt[d]       <= wcnt[d] + 1;
                last_data[d]  <= w_data[d];
                last_flags[d] <= w_flags[d];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    // Drive one frame on line d, 13 clk per bit; optional 1-clk high glitch at mid-bit of bit gbit.
    task automatic send_frame(input int d, input logic [8:0] data, input logic par,
                              input logic s0, input logic s1, input int gbit, input bit measure);
        logic bits [13];
        int   n;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits[d]; i++) begin bits[n] = data[i]; n++; end
        if (has_par[d] != 0) begin bits[n] = par; n++; end
        bits[n] = s0; n++;
        if (nstop[d] == 2) begin bits[n] = s1; n++; end
        lat = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            line[d] = bits[i];
            for (int j = 1; j <= 13; j++) begin
                @(posedge clk); #1;
                if (i == gbit && j == 6)      line[d] = 1'b1;
                else if (i == gbit && j == 7) line[d] = bits[i];
                if (measure && i == n - 1 && lat == 0 && w_valid[d]) lat = j;
            end
        end
        line[d] = 1'b1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       par;
        logic       s0;
        logic       s1;
        logic [8:0] exp_data;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int c0;

        //            dut  data      par   s0    s1    exp_data  {pe,fe,brk,ov}
        vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 4'b0000};
        vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 4'b0000};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 4'b0000};
        vecs[3]  = '{0, 9'h03C, 1'b0, 1'b0, 1'b1, 9'h03C, 4'b0100};
        vecs[4]  = '{0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 4'b0110};
        vecs[5]  = '{1, 9'h003, 1'b1, 1'b1, 1'b1, 9'h003, 4'b1000};
        vecs[6]  = '{1, 9'h003, 1'b0, 1'b1, 1'b1, 9'h003, 4'b0000};
        vecs[7]  = '{1, 9'h080, 1'b1, 1'b1, 1'b1, 9'h080, 4'b0000};
        vecs[8]  = '{1, 9'h05A, 1'b1, 1'b1, 1'b1, 9'h05A, 4'b1000};
        vecs[9]  = '{1, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 4'b0110};
        vecs[10] = '{1, 9'h0C3, 1'b0, 1'b1, 1'b0, 9'h0C3, 4'b0100};
        vecs[11] = '{2, 9'h07F, 1'b0, 1'b0, 1'b1, 9'h07F, 4'b0100};
        vecs[12] = '{2, 9'h02A, 1'b0, 1'b1, 1'b1, 9'h02A, 4'b0000};
        vecs[13] = '{2, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 4'b0110};

        rst_n = 1'b0;
        line  = 3'b111;
        rdy   = 3'b111;
        idle(3);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_valid%0d", d), {31'd0, w_valid[d]}, 32'd0);
            chk($sformatf("reset_data%0d", d),  {23'd0, w_data[d]},  32'd0);
            chk($sformatf("reset_flags%0d", d), {28'd0, w_flags[d]}, 32'd0);
        end
        rst_n = 1'b1;
        idle(5);

        // Table of single frames with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            c0 = wcnt[vecs[i].d];
            send_frame(vecs[i].d, vecs[i].data, vecs[i].par, vecs[i].s0, vecs[i].s1, -1, 1'b0);
            idle(30);
            chk($sformatf("v%0d_words", i), wcnt[vecs[i].d] - c0, 32'd1);
            chk($sformatf("v%0d_data", i),  {23'd0, last_data[vecs[i].d]},  {23'd0, vecs[i].exp_data});
            chk($sformatf("v%0d_flags", i), {28'd0, last_flags[vecs[i].d]}, {28'd0, vecs[i].exp_flags});
        end

        // Latency from driving the stop bit to rx_valid: 2 sync + HALF+1 decide + 1 load.
        c0 = wcnt[0];
        send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        idle(30);
        chk("latency", lat, 32'd10);
        chk("latency_word", {23'd0, last_data[0]}, 32'h0C3);

        // Line held low for 30 bit times: one break word only, no restart until the line rises.
        c0 = wcnt[2];
        @(posedge clk); #1;
        line[2] = 1'b0;
        idle(30 * 13);
        line[2] = 1'b1;
        idle(60);
        chk("break_words", wcnt[2] - c0, 32'd1);
        chk("break_data",  {23'd0, last_data[2]},  32'd0);
        chk("break_flags", {28'd0, last_flags[2]}, 32'h6);

        // Overrun: consumer stalled across two frames.
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idle(20);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idle(20);
        chk("ovr_valid", {31'd0, w_valid[0]}, 32'd1);
        chk("ovr_data",  {23'd0, w_data[0]},  32'h011);
        chk("ovr_flags", {28'd0, w_flags[0]}, 32'h1);
        rdy[0] = 1'b1;
        idle(1);
        rdy[0] = 1'b0;
        idle(1);
        chk("ovr_after_valid", {31'd0, w_valid[0]}, 32'd0);
        chk("ovr_after_flags", {28'd0, w_flags[0]}, 32'd0);
        rdy[0] = 1'b1;
        idle(5);

        // Two-clock low pulse on an idle line is rejected as a false start.
        c0 = wcnt[0];
        line[0] = 1'b0;
        idle(2);
        line[0] = 1'b1;
        idle(60);
        chk("pulse_words", wcnt[0] - c0, 32'd0);
        chk("pulse_valid", {31'd0, w_valid[0]}, 32'd0);

        // One-clock high glitch at the middle of data bit 3 of 0x00 is voted out.
        c0 = wcnt[0];
        send_frame(0, 9'h000, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        idle(30);
        chk("glitch_words", wcnt[0] - c0, 32'd1);
        chk("glitch_data",  {23'd0, last_data[0]},  32'd0);
        chk("glitch_flags", {28'd0, last_flags[0]}, 32'd0);

        // Reset during data bit 4 while a word is held: outputs clear at once.
        rdy[0] = 1'b0;
        send_frame(0, 9'h033, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idle(20);
        chk("held_before_rst", {23'd0, w_data[0]}, 32'h033);
        @(posedge clk); #1;
        line[0] = 1'b0;
        idle(13 * 5 + 6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, w_valid[0]}, 32'd0);
        chk("rst_data",  {23'd0, w_data[0]},  32'd0);
        chk("rst_flags", {28'd0, w_flags[0]}, 32'd0);
        @(posedge clk); #1;
        line[0] = 1'b1;
        idle(3);
        rst_n  = 1'b1;
        rdy[0] = 1'b1;
        idle(20);
        c0 = wcnt[0];
        send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idle(30);
        chk("post_rst_words", wcnt[0] - c0, 32'd1);
        chk("post_rst_data",  {23'd0, last_data[0]},  32'h05A);
        chk("post_rst_flags", {28'd0, last_flags[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
